bid_collector: RTL and testbench
================================

BID_COLLECTOR -- requirements
Module: bid_collector

Interface
REQ-001 Parameter N, default 3: log2 of bidder count; bidder count is 2**N.
REQ-002 Parameter W, default 3: bid width in bits, unsigned.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  upstream bid present.
REQ-006 in_bid  input  W  bid value; bidder index is implied by arrival order.
REQ-007 in_ready  output  1  collector accepts a bid this cycle.
REQ-008 bid  output  (2**N)*W  packed bid bus; slot i occupies bits [(i+1)*W-1 : i*W], matching the auction bus layout.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  downstream consumes the result.
REQ-011 winner  output  N  index of the highest bid.
REQ-012 win_bid  output  W  value of the winning bid.

Function
REQ-013 FSM states LOAD, SEARCH and RESULT; LOAD is the reset state.
REQ-014 LOAD: in_ready = 1; a bid is accepted on an edge where in_valid & in_ready; it is written to slot load_idx, and load_idx increments.
REQ-015 Accepting slot 2**N-1 moves the FSM to SEARCH; load_idx wraps to 0.
REQ-016 in_ready = 0 in SEARCH and RESULT; in_valid is ignored there.
REQ-017 SEARCH scans slots 0..2**N-1, one slot per edge, keeping a running max; on the first slot (index 0), max is loaded unconditionally.
REQ-018 A later slot replaces the running max only if it is strictly greater; ties resolve to the lowest index.
REQ-019 The edge that processes slot 2**N-1 commits winner and win_bid and moves the FSM to RESULT.
REQ-020 Latency: out_valid rises exactly 2**N edges after the edge that accepted the last bid.
REQ-021 RESULT: out_valid = 1; winner, win_bid and bid are held stable until out_valid & out_ready.
REQ-022 On the consuming edge the FSM returns to LOAD; in_ready is 1 on the next cycle; the bid register is retained until overwritten.
REQ-023 out_ready is ignored outside RESULT; out_valid = 0 in LOAD and SEARCH.
REQ-024 bid always reflects the register contents, including partially loaded slots during LOAD.
REQ-025 Comparisons are unsigned, W bits wide; the scan counter is N bits wide and wraps naturally.

Reset
REQ-026 Asserting rst_n = 0 immediately sets: FSM to LOAD, load_idx = 0, scan index = 0, all bid slots = 0, winner = 0, win_bid = 0, out_valid = 0, in_ready = 1.
REQ-027 Reset asserted mid-LOAD or mid-SEARCH discards all collected bids; no partial result is ever presented.
REQ-028 After rst_n deasserts, the first in_valid edge loads slot 0.

Structure
REQ-029 A shared package auction_pkg holds the default N and W constants and the FSM state enum (LOAD, SEARCH, RESULT).
REQ-030 Single module with no sub-modules; the bid bus connects directly to the existing auction block for cross-checking.

Verification
REQ-031 Load bids 6,0,1,4,3,7,5,2 back-to-back -> out_valid 8 edges after the last accept; winner = 5, win_bid = 7; bid = the packed image of the bids.
REQ-032 Load all bids = 4 -> winner = 0, win_bid = 4 (tie rule); load 0,0,0,0,0,0,0,7 -> winner = 7.
REQ-033 Hold out_ready = 0 for 10 cycles in RESULT with in_valid = 1 -> outputs stable, in_ready = 0, no bid accepted; release -> next bid lands in slot 0.
REQ-034 Drive gapped in_valid (1 cycle on, 2 off) -> only 8 bids accepted, result identical to REQ-031.
REQ-035 Pulse rst_n low during SEARCH after loading REQ-031 bids -> out_valid = 0, bid = 0, winner = 0 immediately; a fresh load of 1,2,3,4,5,6,7,0 -> winner = 6, win_bid = 7.
REQ-036 After each result, winner equals the combinational auction block's winner for the same bid bus, checked across 1000 random bid sets.

Source files
------------

// File: rtl/auction_pkg.sv
// Shared auction definitions: default sizing and the collector FSM states.
//   N_DEF : default log2 of bidder count
//   W_DEF : default bid width in bits
package auction_pkg;

    localparam int unsigned N_DEF = 3;
    localparam int unsigned W_DEF = 3;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        SEARCH = 2'd1,
        RESULT = 2'd2
    } state_t;

endpackage

// File: rtl/bid_collector_if.sv
// Bid collector bus: upstream bid stream, downstream result handshake and packed bid image.
//   master : environment side (drives in_valid/in_bid/out_ready)
//   slave  : collector side (drives in_ready, bid, out_valid, winner, win_bid)
interface bid_collector_if
    import auction_pkg::*;
#(
    parameter int unsigned N = N_DEF,
    parameter int unsigned W = W_DEF
);

    logic                 in_valid;
    logic [W-1:0]         in_bid;
    logic                 in_ready;
    logic [(2**N)*W-1:0]  bid;
    logic                 out_valid;
    logic                 out_ready;
    logic [N-1:0]         winner;
    logic [W-1:0]         win_bid;

    modport master (
        output in_valid, in_bid, out_ready,
        input  in_ready, bid, out_valid, winner, win_bid
    );

    modport slave (
        input  in_valid, in_bid, out_ready,
        output in_ready, bid, out_valid, winner, win_bid
    );

endinterface

// File: rtl/bid_collector.sv
// Collects 2**N bids in arrival order, scans them one slot per cycle for the
// highest (lowest index wins ties) and holds the result until consumed.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : bid_collector_if.slave (bid stream in, result out, packed bid bus)
module bid_collector
    import auction_pkg::*;
#(
    parameter int unsigned N = N_DEF,
    parameter int unsigned W = W_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    bid_collector_if.slave bus
);

    localparam int unsigned NUM_SLOTS = 2**N;
    localparam logic [N-1:0] LAST_IDX = N'(NUM_SLOTS - 1);

    state_t         state_q, state_d;
    logic [N-1:0]   load_idx_q, load_idx_d;
    logic [N-1:0]   scan_idx_q, scan_idx_d;
    logic [W-1:0]   slot_q [NUM_SLOTS];
    logic [W-1:0]   slot_d [NUM_SLOTS];
    logic [W-1:0]   max_q, max_d;
    logic [N-1:0]   max_idx_q, max_idx_d;
    logic [N-1:0]   winner_q, winner_d;
    logic [W-1:0]   win_bid_q, win_bid_d;
    logic           in_ready_q, in_ready_d;
    logic           out_valid_q, out_valid_d;

    logic           accept;
    logic           consume;
    logic [W-1:0]   cur_bid;

    // in_ready_q is high exactly in LOAD, out_valid_q exactly in RESULT
    assign accept  = bus.in_valid & in_ready_q;
    assign consume = bus.out_ready & out_valid_q;
    assign cur_bid = slot_q[scan_idx_q];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD:    if (accept && (load_idx_q == LAST_IDX)) state_d = SEARCH;
            SEARCH:  if (scan_idx_q == LAST_IDX)             state_d = RESULT;
            RESULT:  if (consume)                            state_d = LOAD;
            default: state_d = LOAD;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        load_idx_d = load_idx_q;
        scan_idx_d = scan_idx_q;
        slot_d     = slot_q;
        max_d      = max_q;
        max_idx_d  = max_idx_q;
        winner_d   = winner_q;
        win_bid_d  = win_bid_q;

        case (state_q)
            LOAD: begin
                if (accept) begin
                    slot_d[load_idx_q] = bus.in_bid;
                    load_idx_d         = load_idx_q + N'(1);
                end
            end
            SEARCH: begin
                // Slot 0 seeds the running max; later slots must be strictly greater
                if ((scan_idx_q == '0) || (cur_bid > max_q)) begin
                    max_d     = cur_bid;
                    max_idx_d = scan_idx_q;
                end
                scan_idx_d = scan_idx_q + N'(1);
                if (scan_idx_q == LAST_IDX) begin
                    winner_d  = max_idx_d;
                    win_bid_d = max_d;
                end
            end
            default: ;
        endcase

        in_ready_d  = (state_d == LOAD);
        out_valid_d = (state_d == RESULT);
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_idx_q  <= '0;
            scan_idx_q  <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) slot_q[i] <= '0;
            max_q       <= '0;
            max_idx_q   <= '0;
            winner_q    <= '0;
            win_bid_q   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            load_idx_q  <= load_idx_d;
            scan_idx_q  <= scan_idx_d;
            slot_q      <= slot_d;
            max_q       <= max_d;
            max_idx_q   <= max_idx_d;
            winner_q    <= winner_d;
            win_bid_q   <= win_bid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.winner    = winner_q;
    assign bus.win_bid   = win_bid_q;

    // Slot i occupies bits [(i+1)*W-1 : i*W] of the auction bus
    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_bid
        assign bus.bid[g*W +: W] = slot_q[g];
    end

endmodule

// File: tb/tb_bid_collector.sv
// Directed self-checking bench for bid_collector (N=3, W=3).
module tb_bid_collector;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    bid_collector_if #(.N(3), .W(3)) bus ();

    bid_collector #(.N(3), .W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: index of highest bid, lowest index on ties
    function automatic int ref_winner(input logic [23:0] img);
        int w = 0;
        for (int i = 1; i < 8; i++)
            if (img[i*3 +: 3] > img[w*3 +: 3]) w = i;
        return w;
    endfunction

    // Load 8 bids (slot 0 = img[2:0]); gap = idle cycles after each accept
    task automatic load_bids(input logic [23:0] img, input int gap);
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = 1'b1;
            bus.in_bid   = img[i*3 +: 3];
            tick();
            bus.in_valid = 1'b0;
            if (i != 7) repeat (gap) tick();
        end
    endtask

    // Count edges from last accept until out_valid, bounded
    task automatic wait_result(input string tag);
        int cnt = 0;
        while (cnt < 20) begin
            tick();
            cnt++;
            if (bus.out_valid === 1'b1) break;
        end
        check_eq({tag, "_latency"}, 32'(cnt), 32'd8);
    endtask

    task automatic consume(input string tag);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check_eq({tag, "_ov_low"}, 32'(bus.out_valid), 32'd0);
        check_eq({tag, "_ready"},  32'(bus.in_ready),  32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    logic [23:0] img_a;
    logic [23:0] img_b;
    logic [23:0] img_r;

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_bid    = '0;
        bus.out_ready = 1'b0;
        // 6,0,1,4,3,7,5,2 with slot 0 in the low bits
        img_a = {3'd2, 3'd5, 3'd7, 3'd3, 3'd4, 3'd1, 3'd0, 3'd6};
        #12;
        check_eq("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_bid",       32'(bus.bid),       32'd0);
        check_eq("rst_winner",    32'(bus.winner),    32'd0);
        check_eq("rst_win_bid",   32'(bus.win_bid),   32'd0);
        rst_n = 1'b1;
        tick();

        // Back-to-back load
        load_bids(img_a, 0);
        check_eq("b2b_search_ready", 32'(bus.in_ready), 32'd0);
        wait_result("b2b");
        check_eq("b2b_winner",  32'(bus.winner),  32'd5);
        check_eq("b2b_win_bid", 32'(bus.win_bid), 32'd7);
        check_eq("b2b_bid",     32'(bus.bid),     32'(img_a));

        // Backpressure: in_valid asserted but nothing accepted, outputs stable
        bus.in_valid = 1'b1;
        bus.in_bid   = 3'd3;
        for (int c = 0; c < 10; c++) begin
            tick();
            check_eq("hold_out_valid", 32'(bus.out_valid), 32'd1);
            check_eq("hold_in_ready",  32'(bus.in_ready),  32'd0);
            check_eq("hold_winner",    32'(bus.winner),    32'd5);
            check_eq("hold_win_bid",   32'(bus.win_bid),   32'd7);
            check_eq("hold_bid",       32'(bus.bid),       32'(img_a));
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check_eq("rel_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rel_in_ready",  32'(bus.in_ready),  32'd1);
        check_eq("rel_bid_kept",  32'(bus.bid),       32'(img_a));
        tick();
        bus.in_valid = 1'b0;
        img_b = {img_a[23:3], 3'd3};
        check_eq("rel_slot0", 32'(bus.bid), 32'(img_b));
        do_reset();

        // Tie: all 4 -> lowest index
        img_b = {8{3'd4}};
        load_bids(img_b, 0);
        wait_result("tie");
        check_eq("tie_winner",  32'(bus.winner),  32'd0);
        check_eq("tie_win_bid", 32'(bus.win_bid), 32'd4);
        consume("tie");

        // Max in last slot
        img_b = {3'd7, 21'd0};
        load_bids(img_b, 0);
        wait_result("last");
        check_eq("last_winner",  32'(bus.winner),  32'd7);
        check_eq("last_win_bid", 32'(bus.win_bid), 32'd7);
        consume("last");

        // Gapped in_valid (1 on, 2 off)
        load_bids(img_a, 2);
        wait_result("gap");
        check_eq("gap_winner",  32'(bus.winner),  32'd5);
        check_eq("gap_win_bid", 32'(bus.win_bid), 32'd7);
        check_eq("gap_bid",     32'(bus.bid),     32'(img_a));
        consume("gap");

        // Reset mid-SEARCH discards everything
        load_bids(img_a, 0);
        tick();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("msr_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("msr_bid",       32'(bus.bid),       32'd0);
        check_eq("msr_winner",    32'(bus.winner),    32'd0);
        check_eq("msr_in_ready",  32'(bus.in_ready),  32'd1);
        rst_n = 1'b1;
        tick();
        check_eq("msr_no_result", 32'(bus.out_valid), 32'd0);
        img_b = {3'd0, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1};
        load_bids(img_b, 0);
        wait_result("fresh");
        check_eq("fresh_winner",  32'(bus.winner),  32'd6);
        check_eq("fresh_win_bid", 32'(bus.win_bid), 32'd7);
        consume("fresh");

        // Random bid sets against the reference auction
        for (int r = 0; r < 1000; r++) begin
            img_r = 24'($urandom);
            load_bids(img_r, 0);
            wait_result("rnd");
            check_eq("rnd_winner",  32'(bus.winner),  32'(ref_winner(img_r)));
            check_eq("rnd_win_bid", 32'(bus.win_bid), 32'(img_r[ref_winner(img_r)*3 +: 3]));
            consume("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
